// File: rtl/factorial_sequencer.sv
// Multi-cycle n! controller that drives an external combinational ALU using ADD only.
// Optional build macro FACT_OVF_PRECHECK_EN rejects n above the representable limit in LOAD.
module factorial_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_co
);

    typedef enum logic [2:0] {StIdle, StLoad, StMul, StNext, StFinish} state_e;

`ifdef FACT_OVF_PRECHECK_EN
    // Largest n whose factorial still fits in WIDTH bits.
    function automatic int unsigned fact_limit(input int unsigned w);
        longint unsigned p;
        int unsigned     i;
        p = 1;
        i = 1;
        while (p * (i + 1) < (64'd1 << w)) begin
            p = p * (i + 1);
            i = i + 1;
        end
        return i;
    endfunction

    localparam logic [WIDTH-1:0] FactLimit = WIDTH'(fact_limit(WIDTH));
`endif

    state_e           state;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            n_q    <= '0;
            res    <= '0;
            acc    <= '0;
            k      <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        n_q   <= n;
                        busy  <= 1'b1;
                        state <= StLoad;
                    end
                end
                StLoad: begin
                    res    <= WIDTH'(1);
                    acc    <= '0;
                    k      <= WIDTH'(2);
                    cnt    <= WIDTH'(2);
                    result <= '0;
                    ovf    <= 1'b0;
`ifdef FACT_OVF_PRECHECK_EN
                    if (n_q > FactLimit) begin
                        ovf   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StFinish;
                    end else
`endif
                    if (n_q < WIDTH'(2)) begin
                        result <= WIDTH'(1);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= StFinish;
                    end else begin
                        state <= StMul;
                    end
                end
                StMul: begin
                    acc <= alu_out;
                    cnt <= cnt - WIDTH'(1);
                    if (alu_co) begin
                        ovf    <= 1'b1;
                        result <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= StFinish;
                    end else if (cnt == WIDTH'(1)) begin
                        state <= StNext;
                    end
                end
                StNext: begin
                    res <= acc;
                    if (k == n_q) begin
                        result <= acc;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= StFinish;
                    end else begin
                        k     <= k + WIDTH'(1);
                        cnt   <= k + WIDTH'(1);
                        acc   <= '0;
                        state <= StMul;
                    end
                end
                StFinish: state <= StIdle;
                default:  state <= StIdle;
            endcase
        end
    end

    // ALU is driven only while multiplying; idle operands stay at zero.
    assign alu_sel = (state == StMul) ? 2'b10 : 2'b00;
    assign alu_a   = (state == StMul) ? acc : '0;
    assign alu_b   = (state == StMul) ? res : '0;

endmodule

// File: doc/factorial_sequencer.md
Name: factorial_sequencer

Overview:
- Multi-cycle controller that drives the team's 8-bit combinational ALU to compute n! using only the ADD operation (alu_sel = 2'b10).
- Multiplication is done by repeated addition.
- Sits between the top-level start/result interface and the ALU.
- Owns the ALU operand and select inputs, and consumes the ALU result and carry-out.

Parameters:
WIDTH, 8, datapath width of n, the result, the ALU operands and the internal counters; must match the ALU width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
n  input  WIDTH  factorial argument; captured on the edge that accepts start
busy  output  1  high from the accepting edge until done rises
done  output  1  one-cycle pulse; result and ovf are valid from this cycle
result  output  WIDTH  n! when ovf=0; 0 when ovf=1; held until the next accepted start
ovf  output  1  result exceeded WIDTH bits; held until the next accepted start
alu_a  output  WIDTH  ALU operand A (accumulator)
alu_b  output  WIDTH  ALU operand B (current partial product)
alu_sel  output  2  ALU select; 2'b10 (ADD) in MUL, 2'b00 otherwise
alu_out  input  WIDTH  ALU result
alu_co  input  1  ALU carry-out

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset state:
  - State=IDLE.
  - busy, done, ovf = 0; result = 0.
  - alu_a = alu_b = 0; alu_sel = 2'b00.
  - Internal registers res, acc, k, cnt = 0.
- Reset mid-operation: abandons the computation at the next edge; no done pulse.
- States: IDLE, LOAD, MUL, NEXT, FINISH.
- IDLE:
  - On start=1: capture n, go to LOAD, busy=1.
  - start=0: stay.
- LOAD:
  - res<=1, acc<=0, k<=2, cnt<=2; clear result and ovf.
  - If n<2: go to FINISH with result=1.
  - Else go to MUL.
- MUL:
  - alu_a=acc, alu_b=res, alu_sel=2'b10.
  - Each edge: acc<=alu_out, cnt<=cnt-1.
  - If alu_co=1 on any edge: ovf<=1, result<=0, go to FINISH.
  - On the edge where cnt==1 (k-th add): go to NEXT.
- NEXT:
  - res<=acc.
  - If k==n: result<=acc, go to FINISH.
  - Else: k<=k+1, cnt<=k+1, acc<=0, go to MUL.
- FINISH:
  - done=1 for exactly one cycle; busy=0 in this cycle.
  - Go to IDLE.
- Outputs are decoded from registered state/registers only; no combinational path from start or n to any output.
- Latency, from the edge accepting start to the edge where done rises:
  - 1 + Σ_{k=2..n}(k+1) edges when no overflow occurs.
  - n=0 or n=1: 1; n=2: 4; n=5: 19.
  - Overflow: done rises the edge after the overflowing add.
- start is ignored while busy=1, including in FINISH; a new start is accepted in IDLE, earliest the cycle after done.
- Back-to-back operation: start held high continuously causes re-acceptance every time IDLE is reached.
- k, cnt and res are internal WIDTH-bit registers; the k and cnt counters do not use the ALU.
- Valid non-overflow range for WIDTH=8: n ≤ 5 (5! = 120). Any n ≥ 6 must end with ovf=1.
- alu_sel must never take values 2'b01 or 2'b11.

Optional Feature:
- Macro: FACT_OVF_PRECHECK_EN.
- Defined:
  - LOAD compares n against a constant limit: the largest n with n! < 2^WIDTH, which is 5 for WIDTH=8.
  - If n exceeds the limit: ovf<=1, result<=0, go directly to FINISH. Latency is 1, and MUL is never entered.
- Undefined:
  - No precheck; overflow is detected only via alu_co during MUL.
- Results for n ≤ limit are identical in both builds.

Test Plan:
- Reset, then start with n=5 -> done at edge 19 after acceptance; result=8'h78, ovf=0; busy high during edges 0..18; alu_sel only ever 2'b10 or 2'b00.
- n=0, then n=1, each as a separate request -> done 1 edge after acceptance; result=8'h01, ovf=0. n=2 -> result=8'h02 at edge 4.
- n=6 (macro off) -> overflow on the 3rd add of k=6 (120+120+120); done the next edge; ovf=1, result=8'h00.
- n=6 (macro on) -> done 1 edge after acceptance; ovf=1, result=8'h00; alu_sel stays 2'b00 throughout.
- n=4 accepted; start pulsed with n=3 at edge 5 -> second request ignored; result=8'h18 at edge 13; a later start with n=3 gives result=8'h06.
- n=5 accepted; rst=1 at edge 7 -> the next edge shows IDLE, busy=0, done never pulses, result=0; a new start with n=3 gives result=8'h06 at edge 8.
